// File: rtl/seq_count_bcd_ctrl.sv
// Command-driven run/pause/terminal-count controller for a two-digit BCD up-counter.
// Commands arrive over cmd_val/cmd_rdy; done pulses for one cycle when the count reaches the target.
module seq_count_bcd_ctrl #(
  parameter logic [7:0] RESET_TARGET = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_val,
  output logic       cmd_rdy,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_target,
  output logic [7:0] out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  state_t     state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic [7:0] target_reg, target_next;
  logic [7:0] load_clamped;
  logic [7:0] count_inc;
  logic       accept;

  // Out-of-range target digits saturate to 9 so the target stays reachable.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_clamp
      assign load_clamped[gi*4 +: 4] =
        (cmd_target[gi*4 +: 4] > 4'd9) ? 4'd9 : cmd_target[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    count_inc = count_reg;
    if (count_reg[3:0] == 4'd9) begin
      count_inc[3:0] = 4'd0;
      count_inc[7:4] = (count_reg[7:4] == 4'd9) ? 4'd0 : count_reg[7:4] + 4'd1;
    end else begin
      count_inc[3:0] = count_reg[3:0] + 4'd1;
    end
  end

  assign cmd_rdy = (state_reg != DONE);
  assign accept  = cmd_val && cmd_rdy;
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign out     = count_reg;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    target_next = target_reg;
    if (state_reg == DONE) begin
      state_next = IDLE;
    end else if (accept) begin
      // An accepted command wins over the increment and terminal check.
      case (cmd_op)
        OP_CLEAR: begin
          count_next = 8'h00;
          state_next = IDLE;
        end
        OP_START: if (state_reg == IDLE || state_reg == PAUSE) state_next = RUN;
        OP_STOP:  if (state_reg == RUN) state_next = PAUSE;
        OP_LOAD:  target_next = load_clamped;
        default:  state_next = state_reg;
      endcase
    end else if (state_reg == RUN) begin
      if (count_reg == target_reg) state_next = DONE;
      else                         count_next = count_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= 8'h00;
      target_reg <= RESET_TARGET;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      target_reg <= target_next;
    end
  end

endmodule

// File: tb/tb_seq_count_bcd_ctrl.sv
// Bench for seq_count_bcd_ctrl: decimal-arithmetic reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_seq_count_bcd_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_val;
  logic       cmd_rdy;
  logic [1:0] cmd_op;
  logic [7:0] cmd_target;
  logic [7:0] out;
  logic       busy;
  logic       done;

  localparam logic [1:0] CLR = 2'b00, STA = 2'b01, STP = 2'b10, LDT = 2'b11;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain decimal count/target and a run mode.
  int m_count;   // 0..99
  int m_target;  // 0..99
  int m_mode;    // 0 idle, 1 running, 2 paused, 3 finishing

  seq_count_bcd_ctrl #(.RESET_TARGET(8'h99)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_val    (cmd_val),
    .cmd_rdy    (cmd_rdy),
    .cmd_op     (cmd_op),
    .cmd_target (cmd_target),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  function automatic int digit_sat(input logic [3:0] d);
    return (int'(d) > 9) ? 9 : int'(d);
  endfunction

  task automatic model_reset();
    m_count  = 0;
    m_target = 99;
    m_mode   = 0;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] op, input logic [7:0] t);
    if (m_mode == 3) begin
      m_mode = 0;
    end else if (v) begin
      case (op)
        CLR: begin m_count = 0; m_mode = 0; end
        STA: if (m_mode == 0 || m_mode == 2) m_mode = 1;
        STP: if (m_mode == 1) m_mode = 2;
        default: m_target = digit_sat(t[7:4]) * 10 + digit_sat(t[3:0]);
      endcase
    end else if (m_mode == 1) begin
      if (m_count == m_target) m_mode = 3;
      else                     m_count = (m_count + 1) % 100;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("out",     out,            to_bcd(m_count));
    check("busy",    {7'd0, busy},    {7'd0, m_mode == 1});
    check("done",    {7'd0, done},    {7'd0, m_mode == 3});
    check("cmd_rdy", {7'd0, cmd_rdy}, {7'd0, m_mode != 3});
  end

  task automatic step(input bit v, input logic [1:0] op, input logic [7:0] t);
    cmd_val    = v;
    cmd_op     = op;
    cmd_target = t;
    @(posedge clk);
    model_edge(v, op, t);
    #1;
    cmd_val = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, CLR, 8'h00);
  endtask

  initial begin
    cmd_val = 1'b0; cmd_op = CLR; cmd_target = 8'h00;
    reset = 1'b0;
    model_reset();
    #2;
    check("rst_out",  out, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_done", {7'd0, done}, 8'h00);
    check("rst_rdy",  {7'd0, cmd_rdy}, 8'h01);
    #10 reset = 1'b1;

    // Full 00..99 run against the reset target.
    step(1'b1, STA, 8'h00);
    check("start_busy", {7'd0, busy}, 8'h01);
    check("start_out", out, 8'h00);
    idle(1);
    check("first_inc", out, 8'h01);
    idle(98);
    check("reach_99", out, 8'h99);
    idle(1);
    check("done_99", {7'd0, done}, 8'h01);
    check("done_rdy", {7'd0, cmd_rdy}, 8'h00);
    idle(1);
    check("after_done_busy", {7'd0, busy, done}, 8'h00);
    check("after_done_out", out, 8'h99);

    // LOAD 03 then run from 00.
    step(1'b1, CLR, 8'h00);
    step(1'b1, LDT, 8'h03);
    step(1'b1, STA, 8'h00);
    idle(3);
    check("ld3_out", out, 8'h03);
    idle(1);
    check("ld3_done", {6'd0, done, cmd_rdy}, 8'h02);
    idle(1);
    check("ld3_idle", {6'd0, done, busy}, 8'h00);

    // Pause at 05, hold, resume.
    step(1'b1, CLR, 8'h00);
    step(1'b1, LDT, 8'h20);
    step(1'b1, STA, 8'h00);
    idle(5);
    step(1'b1, STP, 8'h00);
    check("stop_out", out, 8'h05);
    check("stop_busy", {7'd0, busy}, 8'h00);
    idle(3);
    check("pause_hold", out, 8'h05);
    step(1'b1, STA, 8'h00);
    check("resume_noinc", out, 8'h05);
    idle(1);
    check("resume_inc", out, 8'h06);
    idle(16);

    // Start above target: wraps through 99 to 00.
    step(1'b1, CLR, 8'h00);
    step(1'b1, LDT, 8'h50);
    step(1'b1, STA, 8'h00);
    idle(52);
    check("at_50", out, 8'h50);
    step(1'b1, LDT, 8'h20);
    step(1'b1, STA, 8'h00);
    idle(50);
    check("wrap_00", out, 8'h00);
    idle(20);
    check("wrap_20", out, 8'h20);
    idle(1);
    check("wrap_done", {7'd0, done}, 8'h01);
    idle(1);

    // Out-of-range load saturates to 99.
    step(1'b1, LDT, 8'hAF);
    step(1'b1, CLR, 8'h00);
    step(1'b1, STA, 8'h00);
    idle(99);
    check("sat_no_done", {7'd0, done}, 8'h00);
    idle(1);
    check("sat_done", {7'd0, done}, 8'h01);
    idle(1);

    // CLEAR mid-run at 37.
    step(1'b1, CLR, 8'h00);
    step(1'b1, STA, 8'h00);
    idle(37);
    check("at_37", out, 8'h37);
    step(1'b1, CLR, 8'h00);
    check("clr_out", out, 8'h00);
    check("clr_flags", {6'd0, busy, done}, 8'h00);

    // Command held across DONE; then START with count already at target.
    step(1'b1, LDT, 8'h02);
    step(1'b1, STA, 8'h00);
    idle(3);
    check("held_in_done", {6'd0, done, cmd_rdy}, 8'h02);
    step(1'b1, STA, 8'h00);
    check("held_not_taken", {6'd0, busy, done}, 8'h00);
    step(1'b1, STA, 8'h00);
    check("held_taken", {7'd0, busy}, 8'h01);
    check("eq_out", out, 8'h02);
    idle(1);
    check("eq_done", {7'd0, done}, 8'h01);
    idle(1);

    // Asynchronous reset between edges during RUN.
    step(1'b1, CLR, 8'h00);
    step(1'b1, STA, 8'h00);
    idle(10);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_out", out, 8'h00);
    check("arst_flags", {6'd0, busy, done}, 8'h00);
    check("arst_rdy", {7'd0, cmd_rdy}, 8'h01);
    @(negedge clk);
    #1 reset = 1'b1;
    step(1'b1, STA, 8'h00);
    check("post_rst_start", {7'd0, busy}, 8'h01);
    idle(2);
    check("post_rst_cnt", out, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
